// File: rtl/npc_pkg.sv
// Shared constants and types for the instruction fetch unit.
package npc_pkg;

    localparam int unsigned IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    // Instruction word carried by fault markers.
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StOut  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch performance counters: delivered instructions and memory stall cycles.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
);

    logic [63:0] fetch_q;
    logic [63:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= 64'd0;
            stall_q <= 64'd0;
        end else begin
            if (fetch_inc) begin
                fetch_q <= fetch_q + 64'd1;
            end
            if (stall_inc) begin
                stall_q <= stall_q + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_q;
    assign perf_stall_cnt = stall_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches words, hands one instruction to decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
`ifdef IFU_PERF_CNT_EN
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt,
`endif
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);

    ifu_state_e      state_q;
    logic [XLEN-1:0] pc_q;
    logic            drop_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_fault_q;

    logic       req_fire;
    logic       inst_fire;
    logic       misaligned;
    ifu_state_e resume_state;

    // A pending stale response blocks new requests so only one is ever outstanding.
    assign mem_req_valid = (state_q == StReq) && !drop_q;
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == StOut);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_fault    = inst_fault_q;

    assign req_fire     = mem_req_valid && mem_req_ready;
    assign inst_fire    = inst_valid && inst_ready;
    assign misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign resume_state = halt ? StIdle : StReq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_q       <= IFU_NOP_INST;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (inst_fire) begin
                pc_q <= pc_q + XLEN'(4);
            end

            // Abandoning an in-flight request: its response must be swallowed.
            if (redirect_valid && (req_fire || (state_q == StWait && !mem_rsp_valid))) begin
                drop_q <= 1'b1;
            end else if (mem_rsp_valid) begin
                drop_q <= 1'b0;
            end

            if (misaligned) begin
                state_q      <= StOut;
                inst_q       <= IFU_NOP_INST;
                inst_pc_q    <= redirect_pc;
                inst_fault_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (!halt) begin
                            state_q <= StReq;
                        end
                    end
                    StReq: begin
                        if (req_fire) begin
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (mem_rsp_valid) begin
                            if (drop_q || redirect_valid) begin
                                state_q <= resume_state;
                            end else begin
                                state_q      <= StOut;
                                inst_q       <= mem_rsp_data;
                                inst_pc_q    <= pc_q;
                                inst_fault_q <= mem_rsp_err;
                            end
                        end
                    end
                    StOut: begin
                        if (inst_fire || redirect_valid) begin
                            state_q <= resume_state;
                        end
                    end
                endcase
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall_inc;
    assign stall_inc = ((state_q == StReq) && !mem_req_ready) ||
                       ((state_q == StWait) && !mem_rsp_valid);

    ifu_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .fetch_inc      (inst_fire),
        .stall_inc      (stall_inc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: memory model, expected-instruction scoreboard,
// and a second instance with a wrapping reset PC.
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_data;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid, halt;
    logic [31:0] redirect_pc;

    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid, w_rsp_err;
    logic [31:0] w_rsp_data;
    logic        w_inst_valid, w_inst_ready, w_inst_fault;
    logic [31:0] w_inst, w_inst_pc;
    logic        w_halt;

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt;
    logic [63:0] w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];

    // Memory model state.
    int unsigned rsp_lat = 1;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    int unsigned req_count = 0;
    bit          pending = 1'b0;
    int unsigned pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    always #5 clk = ~clk;

    ifu_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    ifu_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt (w_perf_fetch_cnt),
        .perf_stall_cnt (w_perf_stall_cnt),
`endif
        .mem_req_valid  (w_req_valid),
        .mem_req_ready  (w_req_ready),
        .mem_req_addr   (w_req_addr),
        .mem_rsp_valid  (w_rsp_valid),
        .mem_rsp_data   (w_rsp_data),
        .mem_rsp_err    (w_rsp_err),
        .inst_valid     (w_inst_valid),
        .inst_ready     (w_inst_ready),
        .inst           (w_inst),
        .inst_pc        (w_inst_pc),
        .inst_fault     (w_inst_fault),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .halt           (w_halt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hC0DE_0000);
    endfunction

    // Responds rsp_lat cycles after acceptance; decisions are made on the falling edge.
    initial begin : mem_model
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            if (pending) begin
                if (pend_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = ovr_en ? ovr_data : mem_word(pend_addr);
                    mem_rsp_err   = err_en && (pend_addr == err_addr);
                    pending       = 1'b0;
                end else begin
                    pend_cnt = pend_cnt - 1;
                end
            end
            if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
                pending   = 1'b1;
                pend_cnt  = rsp_lat - 1;
                pend_addr = mem_req_addr;
                req_count = req_count + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb_q.size() == 0) begin
            e = 'x;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid);
        end
        checks++;
        if (mem_req_addr !== 32'h8000_0000) begin
            failures++; $display("FAIL reset_req_addr: got %h want 80000000", mem_req_addr);
        end
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b0, 32'h0, 32'h8000_0000, 1'b0}) begin
            failures++;
            $display("FAIL reset_inst: got v=%b %h pc=%h f=%b want v=0 0 pc=80000000 f=0",
                     inst_valid, inst, inst_pc, inst_fault);
        end
        checks++;
        if ({w_req_valid, w_req_addr, w_inst_pc} !== {1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL reset_wrap_inst: got v=%b addr=%h pc=%h want 0 fffffffc fffffffc",
                     w_req_valid, w_req_addr, w_inst_pc);
        end
    endtask

    task automatic test_first_fetch();
        exp_t e;
        rst = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL first_cycle1_idle: got %b want 0", mem_req_valid);
        end
        tick();
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0000}) begin
            failures++;
            $display("FAIL first_req: got v=%b addr=%h want 1 80000000", mem_req_valid, mem_req_addr);
        end
        sb_q.push_back('{inst: 32'h0000_0413, pc: 32'h8000_0000, fault: 1'b0});
        tick();
        checks++;
        if ({inst_valid, mem_req_valid} !== 2'b00) begin
            failures++;
            $display("FAIL first_wait: got iv=%b rv=%b want 0 0", inst_valid, mem_req_valid);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++; $display("FAIL first_inst_valid: got %b want 1", inst_valid);
        end
        pop_exp(e);
        checks++;
        if ({inst, inst_pc, inst_fault} !== e) begin
            failures++;
            $display("FAIL first_inst: got %h/%h/%b want %h/%h/%b",
                     inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
    endtask

    task automatic test_ready_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({inst_valid, inst, inst_pc, inst_fault, mem_req_valid} !==
                {1'b1, 32'h0000_0413, 32'h8000_0000, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got iv=%b %h pc=%h f=%b rv=%b want 1 413 80000000 0 0",
                         i, inst_valid, inst, inst_pc, inst_fault, mem_req_valid);
            end
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b1, 32'h8000_0004}) begin
            failures++;
            $display("FAIL stall_next_req: got iv=%b rv=%b addr=%h want 0 1 80000004",
                     inst_valid, mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb_q.push_back('{inst: 32'h40DE_0004, pc: 32'h8000_0004, fault: 1'b0});
        tick();
        tick();
        pop_exp(e);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e}) begin
            failures++;
            $display("FAIL b2b_inst: got v=%b %h/%h/%b want 1 %h/%h/%b",
                     inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
        tick();
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0008}) begin
            failures++;
            $display("FAIL b2b_next_req: got v=%b addr=%h want 1 80000008", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_bus_err();
        exp_t e;
        err_en   = 1'b1;
        err_addr = 32'h8000_0008;
        sb_q.push_back('{inst: 32'h40DE_0008, pc: 32'h8000_0008, fault: 1'b1});
        tick();
        tick();
        pop_exp(e);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e}) begin
            failures++;
            $display("FAIL err_inst: got v=%b %h/%h/%b want 1 %h/%h/%b",
                     inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
        err_en = 1'b0;
        tick();
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_000C}) begin
            failures++;
            $display("FAIL err_next_req: got v=%b addr=%h want 1 8000000c", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        exp_t e;
        rsp_lat = 4;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        ovr_en         = 1'b1;
        ovr_data       = 32'hDEAD_BEEF;
        tick();
        redirect_valid = 1'b0;
        rsp_lat        = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({inst_valid, mem_req_valid} !== 2'b00) begin
                failures++;
                $display("FAIL redir_wait[%0d]: got iv=%b rv=%b want 0 0", i, inst_valid, mem_req_valid);
            end
            tick();
        end
        ovr_en = 1'b0;
        checks++;
        if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b1, 32'h8000_0100}) begin
            failures++;
            $display("FAIL redir_req: got iv=%b rv=%b addr=%h want 0 1 80000100",
                     inst_valid, mem_req_valid, mem_req_addr);
        end
        sb_q.push_back('{inst: 32'h40DE_0100, pc: 32'h8000_0100, fault: 1'b0});
        tick();
        tick();
        pop_exp(e);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e}) begin
            failures++;
            $display("FAIL redir_inst: got v=%b %h/%h/%b want 1 %h/%h/%b",
                     inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
        tick();
    endtask

    task automatic test_misaligned();
        exp_t        e;
        int unsigned rc;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        rc             = req_count;
        sb_q.push_back('{inst: 32'h0, pc: 32'h8000_0102, fault: 1'b1});
        tick();
        redirect_valid = 1'b0;
        pop_exp(e);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e}) begin
            failures++;
            $display("FAIL misalign_inst: got v=%b %h/%h/%b want 1 %h/%h/%b",
                     inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
        checks++;
        if ({mem_req_valid, req_count} !== {1'b0, rc}) begin
            failures++;
            $display("FAIL misalign_no_req: got rv=%b reqs=%0d want 0 %0d", mem_req_valid, req_count, rc);
        end
        // Handshake and redirect together: pc must follow the redirect, not pc+4.
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b1, 32'h8000_0200}) begin
            failures++;
            $display("FAIL out_redirect_req: got iv=%b rv=%b addr=%h want 0 1 80000200",
                     inst_valid, mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        halt = 1'b1;
        sb_q.push_back('{inst: 32'h40DE_0200, pc: 32'h8000_0200, fault: 1'b0});
        tick();
        tick();
        pop_exp(e);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e}) begin
            failures++;
            $display("FAIL halt_drain_inst: got v=%b %h/%h/%b want 1 %h/%h/%b",
                     inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
        tick();
        tick();
        checks++;
        if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b0, 32'h8000_0204}) begin
            failures++;
            $display("FAIL halt_idle: got iv=%b rv=%b addr=%h want 0 0 80000204",
                     inst_valid, mem_req_valid, mem_req_addr);
        end
        halt = 1'b0;
        tick();
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0204}) begin
            failures++;
            $display("FAIL halt_resume: got v=%b addr=%h want 1 80000204", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rsp_lat = 2;
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rsp_lat = 1;
        checks++;
        if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b0, 32'h8000_0000}) begin
            failures++;
            $display("FAIL midreset_state: got iv=%b rv=%b addr=%h want 0 0 80000000",
                     inst_valid, mem_req_valid, mem_req_addr);
        end
        tick();
        checks++;
        if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b1, 32'h8000_0000}) begin
            failures++;
            $display("FAIL midreset_req: got iv=%b rv=%b addr=%h want 0 1 80000000",
                     inst_valid, mem_req_valid, mem_req_addr);
        end
        sb_q.push_back('{inst: 32'h0000_0413, pc: 32'h8000_0000, fault: 1'b0});
        tick();
        tick();
        pop_exp(e);
        checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e}) begin
            failures++;
            $display("FAIL midreset_inst: got v=%b %h/%h/%b want 1 %h/%h/%b",
                     inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
        end
        halt = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        int n_stall = 2;
        checks++;
        if ({w_req_valid, w_req_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_idle: got v=%b addr=%h want 0 fffffffc", w_req_valid, w_req_addr);
        end
        w_halt      = 1'b0;
        w_req_ready = 1'b0;
        tick();
        for (int i = 0; i < n_stall; i++) begin
            checks++;
            if ({w_req_valid, w_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
                failures++;
                $display("FAIL wrap_req_hold[%0d]: got v=%b addr=%h want 1 fffffffc",
                         i, w_req_valid, w_req_addr);
            end
            tick();
        end
        w_req_ready = 1'b1;
        tick();
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b1;
        w_rsp_data   = 32'h0010_0073;
        w_inst_ready = 1'b1;
        w_halt       = 1'b1;
        tick();
        w_rsp_valid = 1'b0;
        checks++;
        if ({w_inst_valid, w_inst, w_inst_pc, w_inst_fault} !==
            {1'b1, 32'h0010_0073, 32'hFFFF_FFFC, 1'b0}) begin
            failures++;
            $display("FAIL wrap_inst: got v=%b %h/%h/%b want 1 00100073/fffffffc/0",
                     w_inst_valid, w_inst, w_inst_pc, w_inst_fault);
        end
        tick();
        checks++;
        if ({w_inst_valid, w_req_valid, w_req_addr} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL wrap_pc: got iv=%b rv=%b addr=%h want 0 0 00000000",
                     w_inst_valid, w_req_valid, w_req_addr);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if ({w_perf_fetch_cnt, w_perf_stall_cnt} !== {64'd1, 64'(n_stall)}) begin
            failures++;
            $display("FAIL wrap_perf: got fetch=%0d stall=%0d want 1 %0d",
                     w_perf_fetch_cnt, w_perf_stall_cnt, n_stall);
        end
`endif
        w_halt = 1'b0;
        tick();
        checks++;
        if ({w_req_valid, w_req_addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL wrap_resume: got v=%b addr=%h want 1 00000000", w_req_valid, w_req_addr);
        end
        w_halt = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        halt           = 1'b0;
        inst_ready     = 1'b0;
        mem_req_ready  = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        w_halt         = 1'b1;
        w_req_ready    = 1'b0;
        w_rsp_valid    = 1'b0;
        w_rsp_data     = 32'h0;
        w_rsp_err      = 1'b0;
        w_inst_ready   = 1'b0;

        test_reset();
        test_first_fetch();
        test_ready_stall();
        test_back_to_back();
        test_bus_err();
        test_redirect_wait();
        test_misaligned();
        test_halt();
        test_reset_mid();
        test_wrap();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained: got %0d left want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
